muldiv_unit: RTL and testbench

- Multi-cycle unsigned multiply/divide execution unit for the 16-bit CPU.
- Sits directly downstream of the 8x16 register file:
  - consumes its two read ports (operands A/B);
  - returns one result through the register-file write port (we/addrR/dataR) on completion.
- Iterative: one shift-add (MUL) or restore-subtract (DIV) step per clock. The control unit stalls on busy.

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit for the 16-bit CPU.
// Reads its operands from the register file's two read ports and returns one
// result through the write port (we_out/addrR_out/dataR_out). MUL uses one
// shift-add step per clock and DIV/REM uses one restoring step per clock.
// Every operation takes a fixed WIDTH+1 cycles from start to done.
// Optional build macro MULDIV_SIGNED_EN adds the sgn input for two's
// complement operation. Signed mode uses operand magnitudes internally and
// fixes the signs when the result is loaded.
module muldiv_unit #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  opA,
   input  logic [WIDTH-1:0]  opB,
   input  logic [ADDR_W-1:0] dest,
`ifdef MULDIV_SIGNED_EN
   input  logic              sgn,
`endif
   output logic              busy,
   output logic              done,
   output logic              we_out,
   output logic [ADDR_W-1:0] addrR_out,
   output logic [WIDTH-1:0]  dataR_out,
   output logic              div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [CNT_W-1:0]     count;
   logic [1:0]           op_r;
   logic                 b_zero;
   logic [WIDTH-1:0]     a_reg;     // multiplicand, or dividend shifting out MSB-first
   logic [WIDTH-1:0]     b_reg;     // multiplier shifting out LSB-first, or divisor
   logic [2*WIDTH-1:0]   acc;       // MUL: partial product; DIV: {remainder, quotient}
   logic [2*WIDTH-1:0]   acc_next;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH+1:0]     div_diff;
   logic                 div_ge;
   logic                 last_step;
   logic                 unused_diff_msb;
`ifdef MULDIV_SIGNED_EN
   logic                 neg_a;
   logic                 neg_b;
`endif

`ifdef MULDIV_SIGNED_EN
   // Apply the signs of the operands to the magnitude result.
   // A divide by zero still returns an all-ones quotient. The remainder keeps
   // the sign of the dividend, so it comes back as opA.
   function automatic logic [WIDTH-1:0] finalize(input logic [1:0] sel,
                                                 input logic [2*WIDTH-1:0] r,
                                                 input logic na,
                                                 input logic nb,
                                                 input logic bz);
      logic [2*WIDTH-1:0] prod;
      logic [WIDTH-1:0]   quo;
      logic [WIDTH-1:0]   rem;
      prod = (na ^ nb) ? -r : r;
      quo  = bz ? '1 : ((na ^ nb) ? -r[WIDTH-1:0] : r[WIDTH-1:0]);
      rem  = na ? -r[2*WIDTH-1:WIDTH] : r[2*WIDTH-1:WIDTH];
      case (sel)
         2'b00:   finalize = prod[WIDTH-1:0];
         2'b01:   finalize = prod[2*WIDTH-1:WIDTH];
         2'b10:   finalize = quo;
         default: finalize = rem;
      endcase
   endfunction
`else
   // The MUL low half and the quotient are both in the low half of acc.
   // The MUL high half and the remainder are both in the high half.
   function automatic logic [WIDTH-1:0] finalize(input logic hi,
                                                 input logic [2*WIDTH-1:0] r);
      finalize = hi ? r[2*WIDTH-1:WIDTH] : r[WIDTH-1:0];
   endfunction
`endif

   // One iteration of shift-add multiply or restoring divide.
   // A zero divisor needs no special case here: every step subtracts, which
   // gives an all-ones quotient and leaves the dividend as the remainder.
   always_comb begin
      mul_sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);
      div_shift       = {acc[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
      div_diff        = {1'b0, div_shift} - {2'b00, b_reg};
      div_ge          = ~div_diff[WIDTH+1];
      unused_diff_msb = div_diff[WIDTH];
      if (op_r[1])
         acc_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
      else
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      last_step = (state == RUN) && (count == CNT_W'(WIDTH-1));
   end

   // Operand and working registers; reset does not touch these.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         op_r   <= op;
         b_zero <= (opB == '0);
         acc    <= '0;
`ifdef MULDIV_SIGNED_EN
         neg_a  <= sgn & opA[WIDTH-1];
         neg_b  <= sgn & opB[WIDTH-1];
         a_reg  <= (sgn && opA[WIDTH-1]) ? -opA : opA;
         b_reg  <= (sgn && opB[WIDTH-1]) ? -opB : opB;
`else
         a_reg  <= opA;
         b_reg  <= opB;
`endif
      end else if (state == RUN) begin
         acc <= acc_next;
         if (op_r[1])
            a_reg <= {a_reg[WIDTH-2:0], 1'b0};
         else
            b_reg <= {1'b0, b_reg[WIDTH-1:1]};
      end
   end

   // Control FSM and registered outputs: IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         we_out      <= 1'b0;
         div_by_zero <= 1'b0;
         addrR_out   <= '0;
         dataR_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done        <= 1'b0;
               we_out      <= 1'b0;
               div_by_zero <= 1'b0;
               if (start) begin
                  addrR_out <= dest;
                  count     <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               count <= count + 1'b1;
               if (last_step) begin
`ifdef MULDIV_SIGNED_EN
                  dataR_out <= finalize(op_r, acc_next, neg_a, neg_b, b_zero);
`else
                  dataR_out <= finalize(op_r[0], acc_next);
`endif
                  div_by_zero <= op_r[1] & b_zero;
                  done        <= 1'b1;
                  we_out      <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               done        <= 1'b0;
               we_out      <= 1'b0;
               div_by_zero <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit with hand-computed results.
// Compile with +define+MULDIV_SIGNED_EN to include the signed vectors.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [15:0] opA;
   logic [15:0] opB;
   logic [2:0]  dest;
`ifdef MULDIV_SIGNED_EN
   logic        sgn;
`endif
   logic        busy;
   logic        done;
   logic        we_out;
   logic [2:0]  addrR_out;
   logic [15:0] dataR_out;
   logic        div_by_zero;

   int n_chk  = 0;
   int n_pass = 0;

   muldiv_unit #(.WIDTH(16), .ADDR_W(3), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .opA         (opA),
      .opB         (opB),
      .dest        (dest),
`ifdef MULDIV_SIGNED_EN
      .sgn         (sgn),
`endif
      .busy        (busy),
      .done        (done),
      .we_out      (we_out),
      .addrR_out   (addrR_out),
      .dataR_out   (dataR_out),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Issue one operation at the current negedge (cycle C) and follow it for up to 20 cycles.
   // intr_at > 0: pulse a conflicting start in cycle C+intr_at.
   // rst_at  > 0: assert reset in cycle C+rst_at and check that the operation aborts.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] d,
                         input logic [15:0] exp_res, input logic exp_dbz,
                         input int intr_at, input int rst_at);
      int early;
      int we_seen;
      early   = 0;
      we_seen = 0;
      start = 1'b1; op = o; opA = a; opB = b; dest = d;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0; opA = 16'hA5A5; opB = 16'h5A5A; dest = 3'd7; op = ~o;
         end
         if (intr_at != 0 && i == intr_at) begin
            start = 1'b1; opA = 16'h0003; opB = 16'h0002; op = 2'b00; dest = 3'd1;
         end
         if (intr_at != 0 && i == intr_at + 1) start = 1'b0;
         if (rst_at == 0) begin
            if (i < 17 && (done || we_out || !busy)) early++;
            if (i == 17) begin
               chk({tag, ".done"},  done, 1'b1);
               chk({tag, ".we"},    we_out, 1'b1);
               chk({tag, ".addr"},  addrR_out, d);
               chk({tag, ".data"},  dataR_out, exp_res);
               chk({tag, ".dbz"},   div_by_zero, exp_dbz);
            end
            if (i == 18) begin
               chk({tag, ".busy_after"}, busy, 1'b0);
               chk({tag, ".done_after"}, done, 1'b0);
               chk({tag, ".timing"}, early, 0);
               break;
            end
         end else begin
            if (we_out) we_seen++;
            if (i == rst_at) reset = 1'b1;
            if (i == rst_at + 1) begin
               reset = 1'b0;
               chk({tag, ".busy_abort"}, busy, 1'b0);
            end
            if (i == 20) begin
               chk({tag, ".no_we"}, we_seen, 0);
               chk({tag, ".data0"}, dataR_out, 16'h0000);
               chk({tag, ".addr0"}, addrR_out, 3'd0);
               chk({tag, ".dbz0"},  div_by_zero, 1'b0);
               chk({tag, ".busy0"}, busy, 1'b0);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0; dest = '0;
`ifdef MULDIV_SIGNED_EN
      sgn = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.we",   we_out, 1'b0);
      chk("rst.addr", addrR_out, 3'd0);
      chk("rst.data", dataR_out, 16'h0000);
      chk("rst.dbz",  div_by_zero, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // Each run ends in the first IDLE cycle, so the next run starts back-to-back.
      run_op("mul_lo",   2'b00, 16'h0123, 16'h0010, 3'd5, 16'h1230, 1'b0, 0, 0);
      run_op("mul_hi_f", 2'b01, 16'hFFFF, 16'hFFFF, 3'd2, 16'hFFFE, 1'b0, 0, 0);
      run_op("mul_lo_f", 2'b00, 16'hFFFF, 16'hFFFF, 3'd0, 16'h0001, 1'b0, 0, 0);
      run_op("mul_hi_x", 2'b01, 16'h1234, 16'h5678, 3'd3, 16'h0626, 1'b0, 0, 0);
      run_op("mul_lo_x", 2'b00, 16'h1234, 16'h5678, 3'd4, 16'h0060, 1'b0, 0, 0);
      run_op("divu",     2'b10, 16'd1000, 16'd7,    3'd4, 16'h008E, 1'b0, 0, 0);
      run_op("remu",     2'b11, 16'd1000, 16'd7,    3'd6, 16'h0006, 1'b0, 0, 0);
      run_op("divu_1",   2'b10, 16'hFFFF, 16'h0001, 3'd7, 16'hFFFF, 1'b0, 0, 0);
      run_op("divu_z",   2'b10, 16'h1234, 16'h0000, 3'd1, 16'hFFFF, 1'b1, 0, 0);
      run_op("remu_z",   2'b11, 16'h1234, 16'h0000, 3'd2, 16'h1234, 1'b1, 0, 0);
      run_op("busy_ign", 2'b10, 16'd1000, 16'd7,    3'd3, 16'h008E, 1'b0, 5, 0);
      run_op("rst_mid",  2'b00, 16'h0123, 16'h0010, 3'd5, 16'h0000, 1'b0, 0, 8);
      run_op("recover",  2'b00, 16'h00FF, 16'h0101, 3'd6, 16'hFFFF, 1'b0, 0, 0);

`ifdef MULDIV_SIGNED_EN
      sgn = 1'b1;
      run_op("s_div",    2'b10, 16'hFFF9, 16'h0002, 3'd1, 16'hFFFD, 1'b0, 0, 0);
      run_op("s_rem",    2'b11, 16'hFFF9, 16'h0002, 3'd2, 16'hFFFF, 1'b0, 0, 0);
      run_op("s_mul",    2'b00, 16'hFFFD, 16'h0003, 3'd3, 16'hFFF7, 1'b0, 0, 0);
      run_op("s_ovf_q",  2'b10, 16'h8000, 16'hFFFF, 3'd4, 16'h8000, 1'b0, 0, 0);
      run_op("s_ovf_r",  2'b11, 16'h8000, 16'hFFFF, 3'd5, 16'h0000, 1'b0, 0, 0);
      run_op("s_rem_z",  2'b11, 16'hFFF9, 16'h0000, 3'd6, 16'hFFF9, 1'b1, 0, 0);
      sgn = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
